// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin
// denominations used for change, and the slot-index width helper.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_e;

   localparam int COIN_DOLLAR  = 100;
   localparam int COIN_QUARTER = 25;
   localparam int COIN_DIME    = 10;
   localparam int COIN_NICKEL  = 5;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/change_payout.sv
// Change hopper driver: holds the unpaid remainder and presents the largest
// coin that fits, one coin per valid/ready handshake.
module change_payout
   import vend_pkg::*;
#(
   parameter int MONEY_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [MONEY_W-1:0] load_value_i,
   input  logic               active_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [MONEY_W-1:0] coin_o,
   output logic               done_o
);

   logic [MONEY_W-1:0] remaining_q, remaining_d;
   logic [MONEY_W-1:0] coin_sel;

   // Greedy pick; anything below a nickel selects nothing and is dropped.
   always_comb begin
      coin_sel = '0;
      if (remaining_q >= MONEY_W'(COIN_DOLLAR))       coin_sel = MONEY_W'(COIN_DOLLAR);
      else if (remaining_q >= MONEY_W'(COIN_QUARTER)) coin_sel = MONEY_W'(COIN_QUARTER);
      else if (remaining_q >= MONEY_W'(COIN_DIME))    coin_sel = MONEY_W'(COIN_DIME);
      else if (remaining_q >= MONEY_W'(COIN_NICKEL))  coin_sel = MONEY_W'(COIN_NICKEL);
   end

   assign valid_o = active_i && (coin_sel != '0);
   assign coin_o  = valid_o ? coin_sel : '0;
   assign done_o  = (coin_sel == '0);

   always_comb begin
      remaining_d = remaining_q;
      if (load_i)
         remaining_d = load_value_i;
      else if (valid_o && ready_i)
         remaining_d = remaining_q - coin_sel;
   end

   always_ff @(posedge clk) begin
      if (reset) remaining_q <= '0;
      else       remaining_q <= remaining_d;
   end

endmodule

// File: rtl/vending_controller.sv
// Vending controller top: credit accumulation, per-slot price/stock tables,
// selection/vend FSM and handoff of the remainder to the change payout.
module vending_controller
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = 9,
   parameter int MONEY_W    = 10,
   parameter int MAX_CREDIT = 500,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 5,
   localparam int IDX_W     = idx_width(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 coinValid,
   input  logic [MONEY_W-1:0]   coinValue,
   input  logic                 selValid,
   input  logic [IDX_W-1:0]     selIdx,
   input  logic                 cancel,
   input  logic                 priceWr,
   input  logic [IDX_W-1:0]     priceIdx,
   input  logic [MONEY_W-1:0]   priceData,
   input  logic                 restockWr,
   input  logic                 changeReady,
   output logic                 changeValid,
   output logic [MONEY_W-1:0]   changeCoin,
   output logic                 coinReturn,
   output logic                 vendValid,
   output logic [IDX_W-1:0]     vendIdx,
   output logic [MONEY_W-1:0]   credit,
   output logic [NUM_ITEMS-1:0] itemAvail,
   output logic [NUM_ITEMS-1:0] itemAfford,
   output logic [MONEY_W-1:0]   dispValue,
   output logic                 dispNeg,
   output logic                 busy
);

   localparam logic [STOCK_W-1:0] STOCK_FULL = '1;

   state_e             state_q, state_d;
   logic [MONEY_W-1:0] credit_q, credit_d;
   logic [MONEY_W-1:0] disp_q, disp_d;
   logic               disp_neg_q, disp_neg_d;
   logic               coin_ret_q, coin_ret_d;
   logic [IDX_W-1:0]   vidx_q, vidx_d;
   logic [MONEY_W-1:0] vprice_q, vprice_d;

   logic [MONEY_W-1:0] price_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

   logic [MONEY_W-1:0] sel_price;
   logic               sel_avail;
   logic [MONEY_W:0]   coin_sum;
   logic               coin_ok, cancel_go, sel_go;
   logic [MONEY_W-1:0] vend_rem;
   logic               pay_load, pay_done;
   logic [MONEY_W-1:0] pay_load_value;

   for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
      assign itemAvail[gi]  = (stock_q[gi] != '0) && (price_q[gi] != '0);
      assign itemAfford[gi] = itemAvail[gi] && (credit_q >= price_q[gi]);
   end

   // Out-of-range selections read as a disabled slot.
   always_comb begin
      sel_price = '0;
      sel_avail = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (selIdx == IDX_W'(i)) begin
            sel_price = price_q[i];
            sel_avail = itemAvail[i];
         end
      end
   end

   assign coin_sum  = {1'b0, credit_q} + {1'b0, coinValue};
   assign coin_ok   = coin_sum <= (MONEY_W+1)'(MAX_CREDIT);
   assign cancel_go = cancel && (credit_q != '0);
   assign sel_go    = !cancel && selValid && (credit_q != '0) && sel_avail
                      && (credit_q >= sel_price);
   assign vend_rem  = credit_q - vprice_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cancel_go)   state_d = ST_CHANGE;
            else if (sel_go) state_d = ST_VEND;
         end
         ST_VEND:   state_d = (vend_rem != '0) ? ST_CHANGE : ST_IDLE;
         ST_CHANGE: if (pay_done) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vendValid   = (state_q == ST_VEND);
      busy        = (state_q != ST_IDLE);
      vendIdx     = vidx_q;
      credit      = credit_q;
      dispValue   = disp_q;
      dispNeg     = disp_neg_q;
      coinReturn  = coin_ret_q;
   end

   always_comb begin
      credit_d   = credit_q;
      disp_d     = disp_q;
      disp_neg_d = disp_neg_q;
      vidx_d     = vidx_q;
      vprice_d   = vprice_q;
      coin_ret_d = coinValid && ((state_q != ST_IDLE) || cancel || selValid);
      case (state_q)
         ST_IDLE: begin
            if (cancel) begin
               if (cancel_go) credit_d = '0;
            end else if (selValid) begin
               if (credit_q == '0) begin
                  disp_d     = sel_price;
                  disp_neg_d = 1'b0;
               end else if (!sel_avail) begin
                  disp_d     = '0;
                  disp_neg_d = 1'b0;
               end else if (credit_q < sel_price) begin
                  disp_d     = sel_price - credit_q;
                  disp_neg_d = 1'b1;
               end else begin
                  vidx_d   = selIdx;
                  vprice_d = sel_price;
               end
            end else if (coinValid) begin
               if (coin_ok) begin
                  credit_d   = coin_sum[MONEY_W-1:0];
                  disp_d     = coin_sum[MONEY_W-1:0];
                  disp_neg_d = 1'b0;
               end else begin
                  coin_ret_d = 1'b1;
               end
            end
         end
         ST_VEND: begin
            credit_d   = '0;
            disp_d     = vend_rem;
            disp_neg_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign pay_load       = ((state_q == ST_IDLE) && cancel_go)
                           || ((state_q == ST_VEND) && (vend_rem != '0));
   assign pay_load_value = (state_q == ST_VEND) ? vend_rem : credit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         credit_q   <= '0;
         disp_q     <= '0;
         disp_neg_q <= 1'b0;
         coin_ret_q <= 1'b0;
         vidx_q     <= '0;
         vprice_q   <= '0;
      end else begin
         credit_q   <= credit_d;
         disp_q     <= disp_d;
         disp_neg_q <= disp_neg_d;
         coin_ret_q <= coin_ret_d;
         vidx_q     <= vidx_d;
         vprice_q   <= vprice_d;
      end
   end

   // Restock wins over a same-cycle vend decrement on the same slot.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (reset) begin
            price_q[i] <= '0;
            stock_q[i] <= STOCK_W'(INIT_STOCK);
         end else begin
            if (priceWr && (priceIdx == IDX_W'(i)))
               price_q[i] <= priceData;
            if (restockWr && (priceIdx == IDX_W'(i)))
               stock_q[i] <= STOCK_FULL;
            else if ((state_q == ST_VEND) && (vidx_q == IDX_W'(i)) && (stock_q[i] != '0))
               stock_q[i] <= stock_q[i] - STOCK_W'(1);
         end
      end
   end

   change_payout #(
      .MONEY_W(MONEY_W)
   ) u_payout (
      .clk         (clk),
      .reset       (reset),
      .load_i      (pay_load),
      .load_value_i(pay_load_value),
      .active_i    (state_q == ST_CHANGE),
      .ready_i     (changeReady),
      .valid_o     (changeValid),
      .coin_o      (changeCoin),
      .done_o      (pay_done)
   );

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: stimulus queues expected vend,
// coin-return and change events; a negedge monitor pops and compares them.
module tb_vending_controller;

   localparam int NUM_ITEMS = 9;
   localparam int MONEY_W   = 10;
   localparam int IDX_W     = 4;
   localparam int EV_RET    = 0;
   localparam int EV_VEND   = 1;
   localparam int EV_CHG    = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 coinValid, selValid, cancel, priceWr, restockWr, changeReady;
   logic [MONEY_W-1:0]   coinValue, priceData;
   logic [IDX_W-1:0]     selIdx, priceIdx;
   logic                 changeValid, coinReturn, vendValid, dispNeg, busy;
   logic [MONEY_W-1:0]   changeCoin, credit, dispValue;
   logic [IDX_W-1:0]     vendIdx;
   logic [NUM_ITEMS-1:0] itemAvail, itemAfford;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   vending_controller dut (
      .clk(clk), .reset(reset),
      .coinValid(coinValid), .coinValue(coinValue),
      .selValid(selValid), .selIdx(selIdx), .cancel(cancel),
      .priceWr(priceWr), .priceIdx(priceIdx), .priceData(priceData),
      .restockWr(restockWr), .changeReady(changeReady),
      .changeValid(changeValid), .changeCoin(changeCoin), .coinReturn(coinReturn),
      .vendValid(vendValid), .vendIdx(vendIdx), .credit(credit),
      .itemAvail(itemAvail), .itemAfford(itemAfford),
      .dispValue(dispValue), .dispNeg(dispNeg), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic expect_ev(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d val=%0d, required none", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            errors++;
            $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d",
                     kind, val, e.kind, e.val);
         end else begin
            $display("event kind=%0d val=%0d ok at %0t", kind, val, $time);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (coinReturn)                 check_ev(EV_RET, 0);
         if (vendValid)                  check_ev(EV_VEND, int'(vendIdx));
         if (changeValid && changeReady) check_ev(EV_CHG, int'(changeCoin));
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input int v, input bit rej);
      if (rej) expect_ev(EV_RET, 0);
      coinValid = 1'b1;
      coinValue = MONEY_W'(v);
      step();
      coinValid = 1'b0;
      coinValue = '0;
   endtask

   task automatic sel(input int idx);
      selValid = 1'b1;
      selIdx   = IDX_W'(idx);
      step();
      selValid = 1'b0;
   endtask

   task automatic press_cancel();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   task automatic set_price(input int idx, input int v);
      priceWr   = 1'b1;
      priceIdx  = IDX_W'(idx);
      priceData = MONEY_W'(v);
      step();
      priceWr   = 1'b0;
   endtask

   task automatic restock(input int idx);
      restockWr = 1'b1;
      priceIdx  = IDX_W'(idx);
      step();
      restockWr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      coinValid = 1'b0; selValid = 1'b0; cancel = 1'b0; priceWr = 1'b0;
      restockWr = 1'b0; changeReady = 1'b1;
      coinValue = '0; priceData = '0; selIdx = '0; priceIdx = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_credit", int'(credit), 0);
      chk("reset_avail", int'(itemAvail), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_disp", int'(dispValue), 0);
      chk("reset_change", int'(changeValid), 0);

      set_price(0, 100);
      set_price(1, 0);
      set_price(2, 125);
      set_price(3, 175);
      chk("avail_after_prices", int'(itemAvail), 13);

      // Exact-price vend, no change
      for (int i = 0; i < 4; i++) coin(25, 0);
      chk("t1_credit", int'(credit), 100);
      chk("t1_afford", int'(itemAfford), 1);
      expect_ev(EV_VEND, 0);
      sel(0);
      wait_idle("t1_idle");
      chk("t1_credit_after", int'(credit), 0);
      chk("t1_disp_after", int'(dispValue), 0);

      // Overpay: 200 for 125 -> three quarters
      coin(100, 0);
      coin(100, 0);
      expect_ev(EV_VEND, 2);
      for (int i = 0; i < 3; i++) expect_ev(EV_CHG, 25);
      sel(2);
      wait_idle("t2_idle");
      chk("t2_credit_after", int'(credit), 0);

      // Credit ceiling
      for (int i = 0; i < 4; i++) coin(100, 0);
      coin(25, 0);
      coin(25, 0);
      chk("t3_credit_450", int'(credit), 450);
      coin(100, 1);
      chk("t3_credit_kept", int'(credit), 450);
      coin(50, 0);
      chk("t3_credit_500", int'(credit), 500);
      chk("t3_disp_500", int'(dispValue), 500);
      for (int i = 0; i < 5; i++) expect_ev(EV_CHG, 100);
      press_cancel();
      wait_idle("t3_idle");

      // Cancel with hopper stalled
      coin(25, 0);
      coin(25, 0);
      coin(10, 0);
      changeReady = 1'b0;
      expect_ev(EV_CHG, 25);
      expect_ev(EV_CHG, 25);
      expect_ev(EV_CHG, 10);
      press_cancel();
      chk("t4_credit_cleared", int'(credit), 0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_valid", int'(changeValid), 1);
         chk("t4_hold_coin", int'(changeCoin), 25);
         step();
      end
      changeReady = 1'b1;
      wait_idle("t4_idle");

      // Drain a slot to empty
      set_price(4, 5);
      for (int i = 0; i < 5; i++) begin
         coin(5, 0);
         if (i == 4) chk("t5_avail_last", int'(itemAvail[4]), 1);
         expect_ev(EV_VEND, 4);
         sel(4);
         wait_idle("t5_idle");
      end
      chk("t5_avail_empty", int'(itemAvail[4]), 0);
      coin(5, 0);
      sel(4);
      chk("t5_no_vend_busy", int'(busy), 0);
      chk("t5_no_vend_credit", int'(credit), 5);
      chk("t5_no_vend_disp", int'(dispValue), 0);
      restock(4);
      chk("t5_restocked", int'(itemAvail[4]), 1);
      expect_ev(EV_CHG, 5);
      press_cancel();
      wait_idle("t5_refund_idle");

      // Shortfall display and coin+select collision
      sel(2);
      chk("t6_price_disp", int'(dispValue), 125);
      chk("t6_price_neg", int'(dispNeg), 0);
      coin(25, 0);
      coin(25, 0);
      sel(3);
      chk("t6_short_disp", int'(dispValue), 125);
      chk("t6_short_neg", int'(dispNeg), 1);
      expect_ev(EV_RET, 0);
      coinValid = 1'b1;
      coinValue = MONEY_W'(25);
      selValid  = 1'b1;
      selIdx    = IDX_W'(3);
      step();
      coinValid = 1'b0;
      selValid  = 1'b0;
      chk("t6_collide_credit", int'(credit), 50);
      chk("t6_collide_disp", int'(dispValue), 125);
      chk("t6_collide_busy", int'(busy), 0);
      expect_ev(EV_CHG, 25);
      expect_ev(EV_CHG, 25);
      press_cancel();
      wait_idle("t6_idle");

      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
